button_scan_ctrl: RTL

BUTTON_SCAN_CTRL -- requirements
Module: button_scan_ctrl

---
 rtl/button_scan_ctrl.sv | 102 ++++++++++
 1 files changed

// File: rtl/button_scan_ctrl.sv
// Scanned button debouncer: a prescaled tick starts a sweep over all buttons, one per cycle,
// and a press is registered once a button has been sampled high HOLD_COUNT times in a row.
module button_scan_ctrl #(
    parameter int unsigned N_BUTTONS      = 4,
    parameter int unsigned PRESCALE_WIDTH = 10,
    parameter int unsigned HOLD_COUNT     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 clear,
    input  logic [N_BUTTONS-1:0] buttons,
    output logic [N_BUTTONS-1:0] toggles,
    output logic [N_BUTTONS-1:0] press,
    output logic                 busy
);
    localparam int unsigned IdxW = (N_BUTTONS > 1) ? $clog2(N_BUTTONS) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(N_BUTTONS - 1);
    localparam logic [7:0] Hold = 8'(HOLD_COUNT);

    typedef enum logic {StIdle, StScan} state_e;

    state_e                    state_q, state_d;
    logic [IdxW-1:0]           idx_q, idx_d;
    logic [PRESCALE_WIDTH-1:0] pre_q, pre_d;
    logic [N_BUTTONS-1:0]      sync1_q, sync2_q;
    logic [7:0]                cnt_q [N_BUTTONS];
    logic [7:0]                cnt_d [N_BUTTONS];
    logic [N_BUTTONS-1:0]      tog_q, tog_d;
    logic [N_BUTTONS-1:0]      press_q, press_d;
    logic                      tick;

    assign tick  = en && (pre_q == '1);
    assign pre_d = en ? pre_q + PRESCALE_WIDTH'(1) : '0;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        tog_d   = tog_q;
        press_d = '0;
        unique case (state_q)
            StIdle: begin
                if (tick) begin
                    state_d = StScan;
                    idx_d   = '0;
                end
            end
            StScan: begin
                if (!sync2_q[idx_q]) begin
                    cnt_d[idx_q] = '0;
                end else if (cnt_q[idx_q] < Hold) begin
                    // Saturation at Hold means one event per continuous hold.
                    cnt_d[idx_q] = cnt_q[idx_q] + 8'd1;
                    if (cnt_q[idx_q] == Hold - 8'd1) begin
                        tog_d[idx_q]   = ~tog_q[idx_q];
                        press_d[idx_q] = 1'b1;
                    end
                end
                if (idx_q == LastIdx) begin
                    state_d = StIdle;
                end else begin
                    idx_d = idx_q + IdxW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
        // Clear overrides a coincident toggle; the press pulse still goes out.
        if (clear) begin
            tog_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            pre_q   <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
            tog_q   <= '0;
            press_q <= '0;
            for (int i = 0; i < N_BUTTONS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pre_q   <= pre_d;
            sync1_q <= buttons;
            sync2_q <= sync1_q;
            tog_q   <= tog_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign toggles = tog_q;
    assign press   = press_q;
    assign busy    = (state_q == StScan);

endmodule
